// File: rtl/pio_arb_pkg.sv
// Shared types and helpers for round-robin arbitration in front of single-port PIO slaves.
// Tag and winner fields are sized for the largest supported requester count.
package pio_arb_pkg;

  localparam int MAX_REQ   = 8;
  localparam int TAG_IDX_W = 3;

  typedef struct packed {
    logic                 valid;
    logic [TAG_IDX_W-1:0] idx;
  } tag_t;

  typedef struct packed {
    logic                 found;
    logic [TAG_IDX_W-1:0] idx;
  } rr_res_t;

  // Bits needed to encode a requester index; never less than one.
  function automatic int idx_w(input int n);
    int w;
    w = 1;
    while ((32'sd1 << w) < n) begin
      w = w + 32'sd1;
    end
    return w;
  endfunction

  // First set bit of req at or after (last+1) mod n, searching upward with wrap.
  function automatic rr_res_t rr_next(input logic [MAX_REQ-1:0]   req,
                                      input logic [TAG_IDX_W-1:0] last,
                                      input int                   n);
    rr_res_t res;
    int      cand;
    res = '0;
    // Walk offsets from farthest to nearest so the nearest hit is written last.
    for (int k = MAX_REQ; k >= 1; k--) begin
      if (k <= n) begin
        cand = (int'(last) + k) % n;
        if (req[cand]) begin
          res.found = 1'b1;
          res.idx   = cand[TAG_IDX_W-1:0];
        end else begin
          res = res;
        end
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/pio_read_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: request vector plus previous winner in,
// one-hot grant and encoded winner out. Shared by every PIO slave front end.
module rr_arbiter
  import pio_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IW      = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last_gnt,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      winner,
  output logic               found
);

  logic [MAX_REQ-1:0] req_ext;
  rr_res_t            res;

  // Rotate-priority search and one-hot decode of the winner.
  always_comb begin
    req_ext                = '0;
    req_ext[NUM_REQ-1:0]   = req;
    res                    = rr_next(req_ext, TAG_IDX_W'(last_gnt), NUM_REQ);
    found                  = res.found;
    winner                 = IW'(res.idx);
    if (res.found) begin
      gnt = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
    end else begin
      gnt = '0;
    end
  end

endmodule

// File: rtl/pio_read_arbiter.sv
// Shares one fixed-latency Avalon-MM PIO read slave among NUM_REQ requesters and
// steers each returned word back to its originator through a latency-matched tag pipe.
module pio_read_arbiter
  import pio_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int ADDR_W       = 2,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic [ADDR_W-1:0]         s_address,
  output logic                      s_read,
  input  logic [DATA_W-1:0]         s_readdata,
  output logic                      busy
);

  localparam int IW = idx_w(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
    $error("pio_read_arbiter: NUM_REQ must be in 2..8");
  end else begin : g_num_req_ok
  end

  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $error("pio_read_arbiter: READ_LATENCY must be in 1..4");
  end else begin : g_latency_ok
  end

  logic [IW-1:0]                 last_gnt_q, last_gnt_d;
  logic [IW-1:0]                 winner;
  logic                          found;
  tag_t [READ_LATENCY-1:0]       tag_q, tag_d;
  tag_t                          tag_exit;
  logic                          any_valid;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req      (req),
    .last_gnt (last_gnt_q),
    .gnt      (gnt),
    .winner   (winner),
    .found    (found)
  );

  // Slave request side: strobe and address follow the grant in the same cycle.
  always_comb begin
    s_read = found;
    if (found) begin
      s_address  = req_addr[int'(winner)*ADDR_W +: ADDR_W];
      last_gnt_d = winner;
    end else begin
      s_address  = '0;
      last_gnt_d = last_gnt_q;
    end
  end

  // Next state of the tag pipe: stage 0 captures this cycle's grant, the rest shift.
  always_comb begin
    tag_d    = tag_q;
    tag_d[0] = {found, TAG_IDX_W'(winner)};
    for (int s = 1; s < READ_LATENCY; s++) begin
      tag_d[s] = tag_q[s-1];
    end
  end

  // Arbiter pointer and tag pipe; reset drops every read still in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_gnt_q <= IW'(NUM_REQ - 1);
      tag_q      <= '0;
    end else begin
      last_gnt_q <= last_gnt_d;
      tag_q      <= tag_d;
    end
  end

  // Return steering: the exiting tag selects the requester, data passes straight through.
  always_comb begin
    tag_exit = tag_q[READ_LATENCY-1];
    if (tag_exit.valid) begin
      rvalid = {{(NUM_REQ-1){1'b0}}, 1'b1} << tag_exit.idx;
      rdata  = s_readdata;
    end else begin
      rvalid = '0;
      rdata  = '0;
    end
  end

  // Activity flag for clock gating / idle detection upstream.
  always_comb begin
    any_valid = 1'b0;
    for (int s = 0; s < READ_LATENCY; s++) begin
      any_valid = any_valid | tag_q[s].valid;
    end
  end

  assign busy = (|req) | any_valid;

endmodule

// File: tb/tb_pio_read_arbiter.sv
// Scoreboard bench: grants checked as issued, expected returns queued and matched by a monitor.
module tb_pio_read_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  always #5 clk = ~clk;

  logic [3:0]  req1, gnt1, rvalid1, req3, gnt3, rvalid3;
  logic [7:0]  addr1, addr3;
  logic [31:0] rdata1, srd1, rdata3, srd3;
  logic [1:0]  sa1, sa3, a3_0, a3_1;
  logic        sr1, sr3, busy1, busy3;

  pio_read_arbiter #(.NUM_REQ(4), .ADDR_W(2), .DATA_W(32), .READ_LATENCY(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .req(req1), .req_addr(addr1), .gnt(gnt1),
    .rvalid(rvalid1), .rdata(rdata1), .s_address(sa1), .s_read(sr1),
    .s_readdata(srd1), .busy(busy1));

  pio_read_arbiter #(.NUM_REQ(4), .ADDR_W(2), .DATA_W(32), .READ_LATENCY(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .req(req3), .req_addr(addr3), .gnt(gnt3),
    .rvalid(rvalid3), .rdata(rdata3), .s_address(sa3), .s_read(sr3),
    .s_readdata(srd3), .busy(busy3));

  function automatic logic [31:0] slave1(input logic [1:0] a);
    case (a)
      2'd0:    return 32'h0000_0001;
      2'd1:    return 32'h2222_2222;
      2'd2:    return 32'h3333_3333;
      default: return 32'h4444_4444;
    endcase
  endfunction

  function automatic logic [31:0] slave3(input logic [1:0] a);
    case (a)
      2'd0:    return 32'h0000_00A5;
      2'd1:    return 32'h0000_005A;
      2'd2:    return 32'h0000_7777;
      default: return 32'h0000_8888;
    endcase
  endfunction

  // Slave models: latency 1 and latency 3 register files.
  always @(posedge clk) srd1 <= slave1(sa1);
  always @(posedge clk) begin
    a3_0 <= sa3;
    a3_1 <= a3_0;
    srd3 <= slave3(a3_1);
  end

  typedef struct {
    int          due;
    logic [3:0]  oh;
    logic [31:0] data;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic mon1();
    if (q1.size() > 0 && q1[0].due == cyc) begin
      chk("rvalid1", 32'(rvalid1), 32'(q1[0].oh));
      chk("rdata1", rdata1, q1[0].data);
      void'(q1.pop_front());
    end else begin
      chk("rvalid1_idle", 32'(rvalid1), 32'd0);
      chk("rdata1_idle", rdata1, 32'd0);
    end
  endtask

  task automatic mon3();
    if (q3.size() > 0 && q3[0].due == cyc) begin
      chk("rvalid3", 32'(rvalid3), 32'(q3[0].oh));
      chk("rdata3", rdata3, q3[0].data);
      void'(q3.pop_front());
    end else begin
      chk("rvalid3_idle", 32'(rvalid3), 32'd0);
      chk("rdata3_idle", rdata3, 32'd0);
    end
  endtask

  // Monitor: count cycles, sample returns just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      mon1();
      mon3();
    end
  end

  // One stimulus cycle on DUT w (1 or 3) with the hand-computed expected grant eg.
  task automatic step(input int w, input logic [3:0] r, input logic [7:0] a,
                      input logic [3:0] eg, input bit push);
    exp_t       e;
    int         wi;
    logic [1:0] ea;
    @(negedge clk);
    if (w == 1) begin req1 = r; addr1 = a; end
    else        begin req3 = r; addr3 = a; end
    #1;
    wi = 0;
    for (int i = 0; i < 4; i++) if (eg[i]) wi = i;
    ea = (eg != 4'd0) ? a[wi*2 +: 2] : 2'd0;
    if (w == 1) begin
      chk("gnt1", 32'(gnt1), 32'(eg));
      chk("s_read1", 32'(sr1), 32'(eg != 4'd0));
      chk("s_address1", 32'(sa1), 32'(ea));
      if (r != 4'd0) chk("busy1_req", 32'(busy1), 32'd1);
    end else begin
      chk("gnt3", 32'(gnt3), 32'(eg));
      chk("s_read3", 32'(sr3), 32'(eg != 4'd0));
      chk("s_address3", 32'(sa3), 32'(ea));
      if (r != 4'd0) chk("busy3_req", 32'(busy3), 32'd1);
    end
    if (push && eg != 4'd0) begin
      e.due = cyc + ((w == 1) ? 1 : 3);
      e.oh  = eg;
      if (w == 1) begin e.data = slave1(ea); q1.push_back(e); end
      else        begin e.data = slave3(ea); q3.push_back(e); end
    end
  endtask

  initial begin
    req1 = 4'd0; req3 = 4'd0; addr1 = 8'd0; addr3 = 8'd0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("busy1_reset", 32'(busy1), 32'd0);
    chk("gnt1_reset", 32'(gnt1), 32'd0);
    chk("s_read1_reset", 32'(sr1), 32'd0);
    reset_n = 1'b1;

    // Single read from requester 0, latency 1.
    step(1, 4'b0001, 8'h00, 4'b0001, 1'b1);
    step(1, 4'b0000, 8'h00, 4'b0000, 1'b1);

    // Latency 3: grants to 0 (addr 0) and 2 (addr 1) on consecutive cycles.
    step(3, 4'b0101, 8'h10, 4'b0001, 1'b1);
    step(3, 4'b0100, 8'h10, 4'b0100, 1'b1);
    repeat (4) step(3, 4'b0000, 8'h00, 4'b0000, 1'b1);

    // Read in flight when reset hits is dropped; no return expected.
    step(3, 4'b0010, 8'h00, 4'b0010, 1'b0);
    @(negedge clk);
    req3    = 4'd0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("busy1_in_reset", 32'(busy1), 32'd0);
    chk("busy3_in_reset", 32'(busy3), 32'd0);
    reset_n = 1'b1;

    // All four requesting right after reset: strict 0,1,2,3 rotation.
    for (int i = 0; i < 8; i++) step(1, 4'b1111, 8'hE4, 4'b0001 << (i % 4), 1'b1);

    // req=1010 rotation, then requester 1 drops before its turn.
    step(1, 4'b0010, 8'hE4, 4'b0010, 1'b1);
    step(1, 4'b1010, 8'hE4, 4'b1000, 1'b1);
    step(1, 4'b1010, 8'hE4, 4'b0010, 1'b1);
    step(1, 4'b1010, 8'hE4, 4'b1000, 1'b1);
    step(1, 4'b0000, 8'hE4, 4'b0000, 1'b1);

    // Lone requester 2 gets back-to-back grants.
    repeat (5) step(1, 4'b0100, 8'h00, 4'b0100, 1'b1);
    repeat (6) step(1, 4'b0000, 8'h00, 4'b0000, 1'b1);

    chk("busy1_idle", 32'(busy1), 32'd0);
    chk("busy3_idle", 32'(busy3), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    chk("q3_drained", 32'(q3.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
